// File: rtl/qoi_decoder.sv
// Streaming QOI chunk decoder: turns a QOI op byte stream into RGBA pixels
// over valid/ready, keeping the 64-entry colour index and the previous pixel.
module qoi_decoder #(
  parameter logic [7:0] PREV_A_INIT = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [29:0] size,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_px,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [29:0] count
);

  typedef enum logic [2:0] {IDLE, OP, ARG, EMIT, DONE} state_t;
  typedef enum logic [1:0] {K_RGB, K_RGBA, K_LUMA} kind_t;

  state_t      state;
  kind_t       kind;
  logic [5:0]  tag6;
  logic [7:0]  arg0, arg1, arg2;
  logic [1:0]  arg_cnt, arg_last;
  logic [5:0]  run_left;
  logic [29:0] size_r;
  logic [31:0] prev;
  logic [31:0] index [64];

  logic [7:0]  pr, pg, pb, pa, dg;
  logic [31:0] diff_px, luma_px, arg_px;
  logic [5:0]  hidx;

  assign in_ready  = (state == OP) || (state == ARG);
  assign out_valid = (state == EMIT);
  assign busy      = in_ready || out_valid;

  assign {pr, pg, pb, pa} = prev;

  // Hash mod 64 only depends on the low 6 bits of each channel.
  assign hidx = out_px[29:24] * 6'd3 + out_px[21:16] * 6'd5
              + out_px[13:8]  * 6'd7 + out_px[5:0]   * 6'd11;

  assign diff_px = {pr + {6'b0, in_data[5:4]} - 8'd2,
                    pg + {6'b0, in_data[3:2]} - 8'd2,
                    pb + {6'b0, in_data[1:0]} - 8'd2,
                    pa};

  // LUMA: the tag byte carries dg, the single argument byte carries dr-dg/db-dg.
  assign dg      = {2'b00, tag6} - 8'd32;
  assign luma_px = {pr + dg + {4'b0, in_data[7:4]} - 8'd8,
                    pg + dg,
                    pb + dg + {4'b0, in_data[3:0]} - 8'd8,
                    pa};

  always_comb begin
    arg_px = luma_px;
    case (kind)
      K_RGB:   arg_px = {arg0, arg1, in_data, pa};
      K_RGBA:  arg_px = {arg0, arg1, arg2, in_data};
      default: arg_px = luma_px;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      kind     <= K_RGB;
      tag6     <= '0;
      arg0     <= '0;
      arg1     <= '0;
      arg2     <= '0;
      arg_cnt  <= '0;
      arg_last <= '0;
      run_left <= '0;
      size_r   <= '0;
      prev     <= {24'h000000, PREV_A_INIT};
      out_px   <= '0;
      count    <= '0;
      done     <= 1'b0;
      for (int unsigned i = 0; i < 64; i++) index[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            size_r <= size;
            count  <= '0;
            prev   <= {24'h000000, PREV_A_INIT};
            done   <= (size == '0);
            state  <= (size == '0) ? DONE : OP;
            for (int unsigned i = 0; i < 64; i++) index[i] <= '0;
          end
        end
        OP: begin
          if (in_valid) begin
            tag6     <= in_data[5:0];
            arg_cnt  <= '0;
            run_left <= '0;
            if (in_data == 8'hFE) begin
              kind <= K_RGB;  arg_last <= 2'd2; state <= ARG;
            end else if (in_data == 8'hFF) begin
              kind <= K_RGBA; arg_last <= 2'd3; state <= ARG;
            end else begin
              case (in_data[7:6])
                2'b00: begin out_px <= index[in_data[5:0]]; state <= EMIT; end
                2'b01: begin out_px <= diff_px; state <= EMIT; end
                2'b10: begin kind <= K_LUMA; arg_last <= 2'd0; state <= ARG; end
                default: begin
                  out_px   <= prev;
                  run_left <= in_data[5:0];
                  state    <= EMIT;
                end
              endcase
            end
          end
        end
        ARG: begin
          if (in_valid) begin
            case (arg_cnt)
              2'd0:    arg0 <= in_data;
              2'd1:    arg1 <= in_data;
              2'd2:    arg2 <= in_data;
              default: ;
            endcase
            arg_cnt <= arg_cnt + 2'd1;
            if (arg_cnt == arg_last) begin
              out_px <= arg_px;
              state  <= EMIT;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            prev        <= out_px;
            index[hidx] <= out_px;
            count       <= count + 30'd1;
            if (count + 30'd1 == size_r) begin
              done  <= 1'b1;
              state <= DONE;
            end else if (run_left != '0) begin
              run_left <= run_left - 6'd1;
            end else begin
              state <= OP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qoi_decoder.sv
// Self-checking bench for qoi_decoder: directed vectors plus random op streams
// compared against a behavioural QOI chunk decoder.
module tb_qoi_decoder;

  localparam logic [7:0] PA = 8'hFF;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] pq_t[$];
  typedef int          iq_t[$];

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [29:0] size, count;
  logic [7:0]  in_data;
  logic [31:0] out_px;

  int errors = 0;
  int checks = 0;

  qoi_decoder #(.PREV_A_INIT(PA)) dut (
    .clk(clk), .rst(rst), .start(start), .size(size),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_px(out_px), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decoder: consumes ops until n pixels exist; returns bytes used.
  function automatic int model(input bq_t bs, input int n, output pq_t px);
    logic [31:0] idx [64];
    logic [31:0] v;
    int r, g, b, a, p, t, d, dgv, run;
    foreach (idx[i]) idx[i] = '0;
    r = 0; g = 0; b = 0; a = PA; p = 0;
    px.delete();
    while (px.size() < n && p < bs.size()) begin
      t = bs[p]; p++; run = 1;
      if (t == 254) begin
        r = bs[p]; g = bs[p+1]; b = bs[p+2]; p += 3;
      end else if (t == 255) begin
        r = bs[p]; g = bs[p+1]; b = bs[p+2]; a = bs[p+3]; p += 4;
      end else begin
        case (t / 64)
          0: begin
            v = idx[t % 64];
            r = v[31:24]; g = v[23:16]; b = v[15:8]; a = v[7:0];
          end
          1: begin
            r = (r + (t / 16) % 4 - 2) & 255;
            g = (g + (t / 4) % 4 - 2) & 255;
            b = (b + t % 4 - 2) & 255;
          end
          2: begin
            d = bs[p]; p++;
            dgv = t % 64 - 32;
            r = (r + dgv + d / 16 - 8) & 255;
            g = (g + dgv) & 255;
            b = (b + dgv + d % 16 - 8) & 255;
          end
          default: run = t % 64 + 1;
        endcase
      end
      for (int k = 0; k < run && px.size() < n; k++) begin
        v = {r[7:0], g[7:0], b[7:0], a[7:0]};
        idx[(r * 3 + g * 5 + b * 7 + a * 11) % 64] = v;
        px.push_back(v);
      end
    end
    return p;
  endfunction

  task automatic gen(output bq_t bs, output int sz);
    int total, len;
    bs.delete();
    sz = $urandom_range(24, 1);
    total = 0;
    while (total < sz) begin
      case ($urandom_range(5, 0))
        0: begin
          bs.push_back(8'hFE);
          repeat (3) bs.push_back(8'($urandom));
        end
        1: begin
          bs.push_back(8'hFF);
          repeat (4) bs.push_back(8'($urandom));
        end
        2: bs.push_back({2'b00, 6'($urandom)});
        3: bs.push_back({2'b01, 6'($urandom)});
        4: begin
          bs.push_back({2'b10, 6'($urandom)});
          bs.push_back(8'($urandom));
        end
        default: begin
          len = $urandom_range(61, 0);
          bs.push_back({2'b11, 6'(len)});
          total += len;
        end
      endcase
      total++;
    end
  endtask

  task automatic run_frame(input string name, input bq_t bs, input pq_t exp, input int sz,
                           input int exp_used, input bit rnd, input int poke, output iq_t hs);
    int cyc, used, extra;
    bit both, fin;
    cyc = 0; used = 0; extra = 0; both = 0; fin = 0;
    hs.delete();
    start = 1'b1; size = 30'(sz);
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 3000) begin
      if (poke == cyc) begin start = 1'b1; size = '0; end
      else start = 1'b0;
      in_valid  = (bs.size() > 0);
      in_data   = (bs.size() > 0) ? bs[0] : 8'h00;
      out_ready = rnd ? ($urandom_range(3, 0) != 0) : 1'b1;
      if (done) fin = 1;
      else begin
        if (in_ready && out_valid) both = 1;
        if (out_valid && out_ready) begin
          hs.push_back(cyc);
          if (exp.size() == 0) extra++;
          else check({name, " px"}, out_px, exp.pop_front());
        end
        if (in_ready && in_valid) begin
          void'(bs.pop_front());
          used++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; in_valid = 1'b0;
    check({name, " done"}, done, 1'b1);
    check({name, " count"}, count, sz);
    check({name, " used"}, used, exp_used);
    check({name, " missing"}, exp.size(), 0);
    check({name, " extra"}, extra, 0);
    check({name, " in_ready"}, in_ready, 1'b0);
    check({name, " busy"}, busy, 1'b0);
    check({name, " both_hi"}, both, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    check("send in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t bs;
    pq_t ex;
    iq_t hs;
    int  sz, used;
    logic [7:0] rgb [4];

    rst = 1'b0; start = 1'b0; size = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst in_ready", in_ready, 1'b0);
    check("rst out_valid", out_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst out_px", out_px, 32'h0);
    check("rst count", count, 30'd0);
    rst = 1'b1;
    @(negedge clk);

    bs = '{8'hFE, 8'h0A, 8'h14, 8'h1E, 8'h55};
    ex = '{32'h0A141EFF};
    run_frame("rgb", bs, ex, 1, 4, 0, -1, hs);

    bs = '{8'hFE, 8'h0A, 8'h14, 8'h1E, 8'hC1};
    ex = '{32'h0A141EFF, 32'h0A141EFF, 32'h0A141EFF};
    run_frame("run", bs, ex, 3, 5, 0, -1, hs);
    if (hs.size() == 3) begin
      check("run op gap", hs[1] - hs[0], 2);
      check("run px gap", hs[2] - hs[1], 1);
    end else check("run handshakes", hs.size(), 3);

    bs = '{8'hFE, 8'h0A, 8'h14, 8'h1E, 8'hC3, 8'h55};
    run_frame("run_trunc", bs, ex, 3, 5, 0, -1, hs);

    bs = '{8'hFE, 8'h0A, 8'h14, 8'h1E, 8'h72};
    ex = '{32'h0A141EFF, 32'h0B121EFF};
    run_frame("diff", bs, ex, 2, 5, 0, -1, hs);

    bs = '{8'hFE, 8'h0A, 8'h14, 8'h1E, 8'hA5, 8'h7A};
    ex = '{32'h0A141EFF, 32'h0E1925FF};
    run_frame("luma", bs, ex, 2, 6, 0, -1, hs);

    bs = '{8'hFE, 8'h00, 8'h00, 8'h00, 8'h4A};
    ex = '{32'h000000FF, 32'hFE0000FF};
    run_frame("wrap", bs, ex, 2, 5, 0, -1, hs);

    bs = '{8'hFE, 8'h0A, 8'h14, 8'h1E, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h09};
    ex = '{32'h0A141EFF, 32'h000000FF, 32'h0A141EFF};
    run_frame("index", bs, ex, 3, 9, 0, -1, hs);
    // same frame with a stray start pulse while busy
    run_frame("mid_start", bs, ex, 3, 9, 1, 4, hs);

    bs = '{8'h55};
    ex = '{};
    run_frame("size0", bs, ex, 0, 0, 0, -1, hs);

    // backpressure on a single RGB pixel
    rgb = '{8'hFE, 8'h0A, 8'h14, 8'h1E};
    out_ready = 1'b0;
    start = 1'b1; size = 30'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(rgb[i]);
    in_valid = 1'b1; in_data = 8'h55;
    check("bp out_valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp out_px", out_px, 32'h0A141EFF);
      check("bp in_ready", in_ready, 1'b0);
      check("bp count", count, 30'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp done", done, 1'b1);
    check("bp count_after", count, 30'd1);
    check("bp out_valid_after", out_valid, 1'b0);

    // asynchronous reset in the middle of a long run
    start = 1'b1; size = 30'd11;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'hFE); send_byte(8'h0A); send_byte(8'h14); send_byte(8'h1E); send_byte(8'hC9);
    repeat (3) @(negedge clk);
    check("mid_rst busy_before", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst out_valid", out_valid, 1'b0);
    check("mid_rst in_ready", in_ready, 1'b0);
    check("mid_rst busy", busy, 1'b0);
    check("mid_rst done", done, 1'b0);
    check("mid_rst count", count, 30'd0);
    check("mid_rst out_px", out_px, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bs = '{8'h05};
    ex = '{32'h00000000};
    run_frame("after_rst", bs, ex, 1, 1, 0, -1, hs);

    for (int f = 0; f < 20; f++) begin
      gen(bs, sz);
      used = model(bs, sz, ex);
      run_frame($sformatf("rand%0d", f), bs, ex, sz, used, 1, -1, hs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
